// File: rtl/count_checker_pkg.sv
// Shared FSM encoding for the count checker and its helpers.
package count_checker_pkg;

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/count_checker.sv
// Sequence checker for a free-running counter bus: locks on +1 steps, then counts skips/repeats.
// Define COUNT_CHECKER_GRAY_EN when the counter drives Gray code instead of plain binary.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             counter_reset,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_value,
    output state_t           state
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] RUN_TGT  = RUN_W'(LOCK_COUNT);
    localparam bit               LOCK_ONE = (LOCK_COUNT == 1);

    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] exp_val;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic             match;

`ifdef COUNT_CHECKER_GRAY_EN
    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray (cnt_in),
        .bin  (val)
    );
`else
    assign val = cnt_in;
`endif

    // Natural WIDTH-bit overflow makes all-ones -> 0 a match.
    assign match   = (val == exp_val);
    assign run_inc = run + 1'b1;

    always_ff @(posedge clk or posedge counter_reset) begin
        if (counter_reset) begin
            state      <= S_SEARCH;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            last_value <= '0;
            exp_val    <= '0;
            run        <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (err_clr) begin
                // A sample arriving with the clear is dropped entirely.
                err_count <= '0;
                state     <= S_SEARCH;
                locked    <= 1'b0;
                run       <= '0;
            end else if (cnt_valid) begin
                exp_val    <= val + 1'b1;
                last_value <= val;
                case (state)
                    S_SEARCH, S_ERROR: begin
                        run    <= RUN_W'(1);
                        state  <= LOCK_ONE ? S_LOCKED : S_ACQUIRE;
                        locked <= LOCK_ONE;
                    end
                    S_ACQUIRE: begin
                        if (match) begin
                            run <= run_inc;
                            if (run_inc == RUN_TGT) begin
                                state  <= S_LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            run <= RUN_W'(1);
                        end
                    end
                    S_LOCKED: begin
                        if (!match) begin
                            err_pulse <= 1'b1;
                            if (err_count != '1) err_count <= err_count + 1'b1;
                            state  <= S_ERROR;
                            locked <= 1'b0;
                        end
                    end
                    default: state <= S_SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_checker.sv
// Directed-vector bench for count_checker (WIDTH=8, LOCK_COUNT=4, ERR_W=16).
module tb_count_checker;
    import count_checker_pkg::*;

    logic        clk = 1'b0;
    logic        counter_reset;
    logic [7:0]  cnt_in;
    logic        cnt_valid;
    logic        err_clr;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [7:0]  last_value;
    state_t      state;

    int n_vec = 0;
    int n_err = 0;

    count_checker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_W(16)) dut (
        .clk           (clk),
        .counter_reset (counter_reset),
        .cnt_in        (cnt_in),
        .cnt_valid     (cnt_valid),
        .err_clr       (err_clr),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .err_count     (err_count),
        .last_value    (last_value),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic [7:0] v, input logic vld, input logic clr);
        @(negedge clk);
        cnt_in    = v;
        cnt_valid = vld;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        counter_reset = 1'b1;
        cnt_valid     = 1'b0;
        err_clr       = 1'b0;
        @(negedge clk);
        counter_reset = 1'b0;
    endtask

    initial begin
        counter_reset = 1'b1;
        cnt_in        = 8'h00;
        cnt_valid     = 1'b0;
        err_clr       = 1'b0;
        #12;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_pulse",  32'(err_pulse), 32'd0);
        chk("rst_count",  32'(err_count), 32'd0);
        chk("rst_last",   32'(last_value), 32'd0);
        chk("rst_state",  32'(state), 32'(S_SEARCH));
        @(negedge clk);
        counter_reset = 1'b0;

        // Basic acquisition
        step(8'd10, 1'b1, 1'b0);
        chk("acq1_state", 32'(state), 32'(S_ACQUIRE));
        step(8'd11, 1'b1, 1'b0);
        step(8'd12, 1'b1, 1'b0);
        chk("acq3_locked", 32'(locked), 32'd0);
        step(8'd13, 1'b1, 1'b0);
        chk("acq4_locked", 32'(locked), 32'd1);
        chk("acq4_state",  32'(state), 32'(S_LOCKED));
        chk("acq4_count",  32'(err_count), 32'd0);
        chk("acq4_last",   32'(last_value), 32'd13);

        // Wrap from 0xFF to 0x00 while locked
        do_reset();
        step(8'hFA, 1'b1, 1'b0);
        step(8'hFB, 1'b1, 1'b0);
        step(8'hFC, 1'b1, 1'b0);
        step(8'hFD, 1'b1, 1'b0);
        step(8'hFE, 1'b1, 1'b0);
        step(8'hFF, 1'b1, 1'b0);
        chk("wrapFF_locked", 32'(locked), 32'd1);
        step(8'h00, 1'b1, 1'b0);
        chk("wrap00_locked", 32'(locked), 32'd1);
        chk("wrap00_pulse",  32'(err_pulse), 32'd0);
        chk("wrap00_last",   32'(last_value), 32'd0);
        step(8'h01, 1'b1, 1'b0);
        chk("wrap01_locked", 32'(locked), 32'd1);
        chk("wrap01_count",  32'(err_count), 32'd0);

        // Skip while locked, then automatic relock
        do_reset();
        step(8'd17, 1'b1, 1'b0);
        step(8'd18, 1'b1, 1'b0);
        step(8'd19, 1'b1, 1'b0);
        step(8'd20, 1'b1, 1'b0);
        chk("skip_pre_locked", 32'(locked), 32'd1);
        step(8'd22, 1'b1, 1'b0);
        chk("skip_pulse",  32'(err_pulse), 32'd1);
        chk("skip_count",  32'(err_count), 32'd1);
        chk("skip_state",  32'(state), 32'(S_ERROR));
        chk("skip_locked", 32'(locked), 32'd0);
        step(8'd0, 1'b0, 1'b0);
        chk("idle_pulse", 32'(err_pulse), 32'd0);
        chk("idle_state", 32'(state), 32'(S_ERROR));
        step(8'd23, 1'b1, 1'b0);
        chk("relock1_state", 32'(state), 32'(S_ACQUIRE));
        step(8'd24, 1'b1, 1'b0);
        step(8'd25, 1'b1, 1'b0);
        chk("relock3_locked", 32'(locked), 32'd0);
        step(8'd26, 1'b1, 1'b0);
        chk("relock4_locked", 32'(locked), 32'd1);
        chk("relock4_count",  32'(err_count), 32'd1);

        // Mismatch during ACQUIRE restarts the run without an error
        step(8'd0, 1'b0, 1'b1);
        chk("clr_state", 32'(state), 32'(S_SEARCH));
        chk("clr_count", 32'(err_count), 32'd0);
        step(8'd5, 1'b1, 1'b0);
        step(8'd6, 1'b1, 1'b0);
        step(8'd9, 1'b1, 1'b0);
        chk("acqmis_state", 32'(state), 32'(S_ACQUIRE));
        chk("acqmis_pulse", 32'(err_pulse), 32'd0);
        chk("acqmis_count", 32'(err_count), 32'd0);
        step(8'd10, 1'b1, 1'b0);
        step(8'd11, 1'b1, 1'b0);
        chk("acqmis11_locked", 32'(locked), 32'd0);
        step(8'd12, 1'b1, 1'b0);
        chk("acqmis12_locked", 32'(locked), 32'd1);

        // err_clr coincident with a mismatch
        step(8'd40, 1'b1, 1'b0);
        chk("pre_clr_count", 32'(err_count), 32'd1);
        step(8'd41, 1'b1, 1'b0);
        step(8'd42, 1'b1, 1'b0);
        step(8'd43, 1'b1, 1'b0);
        step(8'd44, 1'b1, 1'b0);
        chk("pre_clr_locked", 32'(locked), 32'd1);
        step(8'd50, 1'b1, 1'b1);
        chk("clrmis_pulse", 32'(err_pulse), 32'd0);
        chk("clrmis_count", 32'(err_count), 32'd0);
        chk("clrmis_state", 32'(state), 32'(S_SEARCH));
        chk("clrmis_last",  32'(last_value), 32'd44);

        // Asynchronous reset in the middle of a lock
        step(8'd45, 1'b1, 1'b0);
        step(8'd46, 1'b1, 1'b0);
        step(8'd47, 1'b1, 1'b0);
        step(8'd48, 1'b1, 1'b0);
        chk("prerst_locked", 32'(locked), 32'd1);
        cnt_valid = 1'b0;
        #1;
        counter_reset = 1'b1;
        #1;
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_state",  32'(state), 32'(S_SEARCH));
        chk("arst_last",   32'(last_value), 32'd0);
        chk("arst_count",  32'(err_count), 32'd0);
        @(negedge clk);
        counter_reset = 1'b0;

`ifdef COUNT_CHECKER_GRAY_EN
        step(8'h00, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        step(8'h03, 1'b1, 1'b0);
        chk("gray03_last", 32'(last_value), 32'd2);
        step(8'h02, 1'b1, 1'b0);
        chk("gray_locked", 32'(locked), 32'd1);
        do_reset();
        step(8'h00, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        step(8'h02, 1'b1, 1'b0);
        chk("raw02_last", 32'(last_value), 32'd3);
        step(8'h03, 1'b1, 1'b0);
        chk("raw_locked", 32'(locked), 32'd0);
        chk("raw_state",  32'(state), 32'(S_ACQUIRE));
`else
        step(8'h00, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        step(8'h02, 1'b1, 1'b0);
        chk("bin02_last", 32'(last_value), 32'd2);
        step(8'h03, 1'b1, 1'b0);
        chk("bin_locked", 32'(locked), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
